// File: rtl/rd_writeback_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rd_writeback_unit: merges ALU results and queued load responses into one
// registered register-file write port.                          Revision: 1.0
// ----------------------------------------------------------------------------
module rd_writeback_unit #(
  parameter int REGISTER_WIDTH = 32,
  parameter int REGISTER_DEPTH = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              ALU_VALID,
  input  logic [$clog2(REGISTER_DEPTH)-1:0] ALU_RD_ADDRESS,
  input  logic [REGISTER_WIDTH-1:0]         ALU_RD_DATA,
  input  logic                              LOAD_VALID,
  output logic                              LOAD_READY,
  input  logic [$clog2(REGISTER_DEPTH)-1:0] LOAD_RD_ADDRESS,
  input  logic [2:0]                        LOAD_FUNCT3,
  input  logic [1:0]                        LOAD_BYTE_OFFSET,
  input  logic [REGISTER_WIDTH-1:0]         LOAD_WORD,
  output logic [$clog2(REGISTER_DEPTH)-1:0] RD_ADDRESS,
  output logic [REGISTER_WIDTH-1:0]         RD_DATA,
  output logic                              RD_WRITE_EN,
  output logic [REGISTER_DEPTH-1:0]         PENDING_MASK,
  output logic [$clog2(FIFO_DEPTH):0]       FIFO_COUNT
);

  localparam int AW = $clog2(REGISTER_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic                      live_q [FIFO_DEPTH];
  logic                      live_d [FIFO_DEPTH];
  logic [AW-1:0]             addr_q [FIFO_DEPTH];
  logic [AW-1:0]             addr_d [FIFO_DEPTH];
  logic [REGISTER_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [REGISTER_WIDTH-1:0] data_d [FIFO_DEPTH];

  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;

  logic                      rd_we_q, rd_we_d;
  logic [AW-1:0]             rd_addr_q, rd_addr_d;
  logic [REGISTER_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                      alu_active;
  logic                      push;
  logic                      pop;
  logic [7:0]                load_byte;
  logic [15:0]               load_half;
  logic [REGISTER_WIDTH-1:0] load_ext;
  logic [REGISTER_DEPTH-1:0] pending;

  assign LOAD_READY = RST_N && (count_q < FULL_COUNT);

  always_comb begin
    load_byte = LOAD_WORD[{LOAD_BYTE_OFFSET, 3'b000} +: 8];
    load_half = LOAD_WORD[{LOAD_BYTE_OFFSET[1], 4'b0000} +: 16];
    case (LOAD_FUNCT3)
      3'b000:  load_ext = {{(REGISTER_WIDTH-8){load_byte[7]}}, load_byte};
      3'b001:  load_ext = {{(REGISTER_WIDTH-16){load_half[15]}}, load_half};
      3'b100:  load_ext = {{(REGISTER_WIDTH-8){1'b0}}, load_byte};
      3'b101:  load_ext = {{(REGISTER_WIDTH-16){1'b0}}, load_half};
      default: load_ext = LOAD_WORD;
    endcase
  end

  // A write to x0 counts as an idle ALU so the queue can drain.
  always_comb begin
    alu_active = ALU_VALID && (ALU_RD_ADDRESS != '0);
    push       = LOAD_VALID && LOAD_READY && (LOAD_RD_ADDRESS != '0);
    pop        = !alu_active && (count_q != '0);

    for (int i = 0; i < FIFO_DEPTH; i++) begin
      live_d[i] = live_q[i];
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
      if (alu_active && live_q[i] && (addr_q[i] == ALU_RD_ADDRESS)) begin
        live_d[i] = 1'b0;
      end
    end

    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
    end

    // The pushed load is younger than a same-edge ALU result, so it stays live.
    if (push) begin
      live_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q] = LOAD_RD_ADDRESS;
      data_d[wr_ptr_q] = load_ext;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    rd_we_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (alu_active) begin
      rd_we_d   = 1'b1;
      rd_addr_d = ALU_RD_ADDRESS;
      rd_data_d = ALU_RD_DATA;
    end else if (pop) begin
      rd_we_d   = live_q[rd_ptr_q];
      rd_addr_d = addr_q[rd_ptr_q];
      rd_data_d = data_q[rd_ptr_q];
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (live_q[i]) begin
        pending[addr_q[i]] = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        live_q[i] <= 1'b0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        live_q[i] <= live_d[i];
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_we_q   <= rd_we_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign RD_WRITE_EN  = rd_we_q;
  assign RD_ADDRESS   = rd_addr_q;
  assign RD_DATA      = rd_data_q;
  assign PENDING_MASK = pending;
  assign FIFO_COUNT   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_rd_writeback_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rd_writeback_unit: directed self-checking bench for rd_writeback_unit.
//                                                                Revision: 1.0
// ----------------------------------------------------------------------------
module tb_rd_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_v = 1'b0;
  logic [4:0]  alu_a = '0;
  logic [31:0] alu_d = '0;
  logic        ld_v = 1'b0;
  logic        ld_rdy;
  logic [4:0]  ld_a = '0;
  logic [2:0]  ld_f3 = 3'b010;
  logic [1:0]  ld_off = '0;
  logic [31:0] ld_w = '0;
  logic [4:0]  rd_a;
  logic [31:0] rd_d;
  logic        rd_we;
  logic [31:0] mask;
  logic [2:0]  cnt;

  int n_cmp = 0;
  int n_err = 0;

  rd_writeback_unit #(
    .REGISTER_WIDTH(32),
    .REGISTER_DEPTH(32),
    .FIFO_DEPTH(4)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .ALU_VALID(alu_v),
    .ALU_RD_ADDRESS(alu_a),
    .ALU_RD_DATA(alu_d),
    .LOAD_VALID(ld_v),
    .LOAD_READY(ld_rdy),
    .LOAD_RD_ADDRESS(ld_a),
    .LOAD_FUNCT3(ld_f3),
    .LOAD_BYTE_OFFSET(ld_off),
    .LOAD_WORD(ld_w),
    .RD_ADDRESS(rd_a),
    .RD_DATA(rd_d),
    .RD_WRITE_EN(rd_we),
    .PENDING_MASK(mask),
    .FIFO_COUNT(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Accept one load with the ALU idle and check the write two edges later.
  task automatic do_load(input string tag, input logic [4:0] a, input logic [2:0] f3,
                         input logic [1:0] off, input logic [31:0] w, input logic [31:0] exp);
    ld_v = 1'b1; ld_a = a; ld_f3 = f3; ld_off = off; ld_w = w;
    tick();
    ld_v = 1'b0;
    chk({tag, "_cnt"}, 64'(cnt), 64'd1);
    chk({tag, "_nowe"}, 64'(rd_we), 64'd0);
    tick();
    chk({tag, "_we"}, 64'(rd_we), 64'd1);
    chk({tag, "_addr"}, 64'(rd_a), 64'(a));
    chk({tag, "_data"}, 64'(rd_d), 64'(exp));
    chk({tag, "_cnt0"}, 64'(cnt), 64'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick();
    chk("rst_we", 64'(rd_we), 64'd0);
    chk("rst_addr", 64'(rd_a), 64'd0);
    chk("rst_data", 64'(rd_d), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_mask", 64'(mask), 64'd0);
    chk("rst_ready", 64'(ld_rdy), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(ld_rdy), 64'd1);
    chk("idle_we", 64'(rd_we), 64'd0);

    // ALU single write
    alu_v = 1'b1; alu_a = 5'd5; alu_d = 32'h12345678;
    tick();
    alu_v = 1'b0;
    chk("alu_we", 64'(rd_we), 64'd1);
    chk("alu_addr", 64'(rd_a), 64'd5);
    chk("alu_data", 64'(rd_d), 64'h12345678);
    tick();
    chk("alu_we_off", 64'(rd_we), 64'd0);
    chk("alu_addr_hold", 64'(rd_a), 64'd5);

    // Load extension
    do_load("lb2",  5'd8, 3'b000, 2'd2, 32'h8080FF00, 32'hFFFFFF80);
    do_load("lbu2", 5'd8, 3'b100, 2'd2, 32'h8080FF00, 32'h00000080);
    do_load("lh2",  5'd8, 3'b001, 2'd2, 32'h8080FF00, 32'hFFFF8080);
    do_load("lhu0", 5'd8, 3'b101, 2'd0, 32'h8080FF00, 32'h0000FF00);
    do_load("lb1",  5'd9, 3'b000, 2'd1, 32'h8080FF00, 32'hFFFFFFFF);
    do_load("lhu3", 5'd9, 3'b101, 2'd3, 32'h1234ABCD, 32'h00001234);
    do_load("lw",   5'd9, 3'b010, 2'd3, 32'hCAFEF00D, 32'hCAFEF00D);
    do_load("f3_7", 5'd9, 3'b111, 2'd1, 32'h80000001, 32'h80000001);

    // Back-pressure: ALU busy to x1, five loads to x10..x14
    alu_v = 1'b1; alu_a = 5'd1; alu_d = 32'h111;
    ld_v = 1'b1; ld_f3 = 3'b010; ld_off = 2'd0;
    for (int k = 0; k < 4; k++) begin
      ld_a = 5'(10 + k); ld_w = 32'hA0 + 32'(10 + k);
      tick();
    end
    ld_a = 5'd14; ld_w = 32'hA0 + 32'd14;
    chk("bp_cnt4", 64'(cnt), 64'd4);
    chk("bp_ready0", 64'(ld_rdy), 64'd0);
    chk("bp_mask", 64'(mask), 64'h3C00);
    tick();
    chk("bp_held_cnt", 64'(cnt), 64'd4);
    chk("bp_held_ready", 64'(ld_rdy), 64'd0);
    chk("bp_alu_addr", 64'(rd_a), 64'd1);
    chk("bp_alu_we", 64'(rd_we), 64'd1);
    alu_v = 1'b0;
    tick();
    chk("bp_w10_addr", 64'(rd_a), 64'd10);
    chk("bp_w10_data", 64'(rd_d), 64'hAA);
    chk("bp_w10_cnt", 64'(cnt), 64'd3);
    tick();
    ld_v = 1'b0;
    chk("bp_w11_addr", 64'(rd_a), 64'd11);
    chk("bp_w11_we", 64'(rd_we), 64'd1);
    chk("bp_w11_cnt", 64'(cnt), 64'd3);
    chk("bp_w11_mask", 64'(mask), 64'h7000);
    tick();
    chk("bp_w12_addr", 64'(rd_a), 64'd12);
    chk("bp_w12_cnt", 64'(cnt), 64'd2);
    tick();
    chk("bp_w13_addr", 64'(rd_a), 64'd13);
    chk("bp_w13_we", 64'(rd_we), 64'd1);
    tick();
    chk("bp_w14_addr", 64'(rd_a), 64'd14);
    chk("bp_w14_data", 64'(rd_d), 64'hAE);
    chk("bp_w14_cnt", 64'(cnt), 64'd0);
    tick();
    chk("bp_idle_we", 64'(rd_we), 64'd0);

    // Squash
    alu_v = 1'b1; alu_a = 5'd3; alu_d = 32'h33;
    ld_v = 1'b1; ld_a = 5'd7; ld_f3 = 3'b010; ld_w = 32'h55;
    tick();
    ld_v = 1'b0;
    alu_a = 5'd7; alu_d = 32'hAA;
    chk("sq_mask_set", 64'(mask), 64'h80);
    chk("sq_alu3_addr", 64'(rd_a), 64'd3);
    tick();
    alu_v = 1'b0;
    chk("sq_mask_clr", 64'(mask), 64'h0);
    chk("sq_cnt_kept", 64'(cnt), 64'd1);
    chk("sq_alu7_addr", 64'(rd_a), 64'd7);
    chk("sq_alu7_data", 64'(rd_d), 64'hAA);
    tick();
    chk("sq_pop_we", 64'(rd_we), 64'd0);
    chk("sq_pop_cnt", 64'(cnt), 64'd0);

    // x0 handling: ALU to x0 lets the queue drain
    ld_v = 1'b1; ld_a = 5'd9; ld_w = 32'h99;
    tick();
    ld_v = 1'b0;
    alu_v = 1'b1; alu_a = 5'd0; alu_d = 32'hDEAD;
    chk("x0_cnt1", 64'(cnt), 64'd1);
    tick();
    alu_v = 1'b0;
    chk("x0_drain_we", 64'(rd_we), 64'd1);
    chk("x0_drain_addr", 64'(rd_a), 64'd9);
    chk("x0_drain_data", 64'(rd_d), 64'h99);
    chk("x0_drain_cnt", 64'(cnt), 64'd0);
    ld_v = 1'b1; ld_a = 5'd0; ld_w = 32'h1234;
    tick();
    ld_v = 1'b0;
    chk("x0_load_cnt", 64'(cnt), 64'd0);
    chk("x0_load_mask", 64'(mask), 64'd0);
    chk("x0_load_ready", 64'(ld_rdy), 64'd1);
    tick();
    chk("x0_load_nowe", 64'(rd_we), 64'd0);

    // Reset mid-operation with three entries queued
    alu_v = 1'b1; alu_a = 5'd2; alu_d = 32'h22;
    ld_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ld_a = 5'(20 + k); ld_w = 32'h200 + 32'(k);
      tick();
    end
    ld_v = 1'b0;
    chk("rs_cnt3", 64'(cnt), 64'd3);
    chk("rs_mask", 64'(mask), 64'h0070_0000);
    #2 rst_n = 1'b0;
    alu_v = 1'b0;
    #1;
    chk("rs_we", 64'(rd_we), 64'd0);
    chk("rs_addr", 64'(rd_a), 64'd0);
    chk("rs_data", 64'(rd_d), 64'd0);
    chk("rs_cnt", 64'(cnt), 64'd0);
    chk("rs_mask0", 64'(mask), 64'd0);
    chk("rs_ready", 64'(ld_rdy), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rs_post_we", 64'(rd_we), 64'd0);
      chk("rs_post_cnt", 64'(cnt), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
